switch_conditioner: RTL and testbench

SWITCH_CONDITIONER -- requirements
Module: switch_conditioner

---
 rtl/switch_conditioner.sv | 70 +++++++
 tb/tb_switch_conditioner.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/switch_conditioner.sv
// Two-channel push-button conditioner: 2-flop synchroniser, debounce counter
// and registered one-cycle press pulse per channel (channel 0 = on, 1 = off).
module switch_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic CLK,
    input  logic RST,
    input  logic SW_ON_RAW,
    input  logic SW_OFF_RAW,
    output logic SW_ON,
    output logic SW_OFF,
    output logic ON_LVL,
    output logic OFF_LVL
);

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } ch_state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0] raw;
    assign raw = {SW_OFF_RAW, SW_ON_RAW};

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic             sync1;
        logic             sync2;
        logic             lvl;
        logic             pulse;
        logic [CNT_W-1:0] cnt;
        ch_state_e        state;

        // State is not stored: it is the comparison of synchronised input and level.
        always_comb state = (sync2 == lvl) ? STABLE : PENDING;

        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
                lvl   <= 1'b0;
                cnt   <= '0;
                pulse <= 1'b0;
            end else begin
                sync1 <= raw[ch];
                sync2 <= sync1;
                pulse <= 1'b0;
                case (state)
                    STABLE: cnt <= '0;
                    PENDING: begin
                        if (cnt == CNT_LAST) begin
                            lvl   <= sync2;
                            cnt   <= '0;
                            pulse <= sync2;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign SW_ON   = g_ch[0].pulse;
    assign SW_OFF  = g_ch[1].pulse;
    assign ON_LVL  = g_ch[0].lvl;
    assign OFF_LVL = g_ch[1].lvl;

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner: default (4) and minimum (1) debounce depth,
// checked every cycle against a sliding-window reference model.
module tb_switch_conditioner;

    localparam int DC [2] = '{4, 1};

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic sw_on_raw = 1'b0;
    logic sw_off_raw = 1'b0;

    logic sw_on4, sw_off4, on_lvl4, off_lvl4;
    logic sw_on1, sw_off1, on_lvl1, off_lvl1;
    logic [3:0] obs [2];

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    int npulse = 0;

    switch_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .CLK(CLK), .RST(RST), .SW_ON_RAW(sw_on_raw), .SW_OFF_RAW(sw_off_raw),
        .SW_ON(sw_on4), .SW_OFF(sw_off4), .ON_LVL(on_lvl4), .OFF_LVL(off_lvl4)
    );

    switch_conditioner #(.DEBOUNCE_CYCLES(1)) dut1 (
        .CLK(CLK), .RST(RST), .SW_ON_RAW(sw_on_raw), .SW_OFF_RAW(sw_off_raw),
        .SW_ON(sw_on1), .SW_OFF(sw_off1), .ON_LVL(on_lvl1), .OFF_LVL(off_lvl1)
    );

    assign obs[0] = {sw_on4, sw_off4, on_lvl4, off_lvl4};
    assign obs[1] = {sw_on1, sw_off1, on_lvl1, off_lvl1};

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (on,off,on_lvl,off_lvl) at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a level is accepted once the last D synchronised samples
    // (raw delayed two edges) all disagree with the current level.
    logic       m_lvl   [2][2];
    logic       m_pulse [2][2];
    logic [1:0] rh      [2][2];
    logic [7:0] s2h     [2][2];

    function automatic bit accept(input logic [7:0] win, input logic lvl, input int d);
        logic [7:0] mask;
        mask = 8'((1 << d) - 1);
        return lvl ? ((win & mask) == 8'h00) : ((win & mask) == mask);
    endfunction

    always @(posedge CLK or negedge RST) begin
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (!RST) begin
                    m_lvl[i][c]   <= 1'b0;
                    m_pulse[i][c] <= 1'b0;
                    rh[i][c]      <= 2'b00;
                    s2h[i][c]     <= 8'h00;
                end else begin
                    s2h[i][c] <= {s2h[i][c][6:0], rh[i][c][1]};
                    rh[i][c]  <= {rh[i][c][0], (c == 0) ? sw_on_raw : sw_off_raw};
                    if (accept({s2h[i][c][6:0], rh[i][c][1]}, m_lvl[i][c], DC[i])) begin
                        m_lvl[i][c]   <= ~m_lvl[i][c];
                        m_pulse[i][c] <= ~m_lvl[i][c];
                    end else begin
                        m_pulse[i][c] <= 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check_eq("model_d4", obs[0], {m_pulse[0][0], m_pulse[0][1], m_lvl[0][0], m_lvl[0][1]});
            check_eq("model_d1", obs[1], {m_pulse[1][0], m_pulse[1][1], m_lvl[1][0], m_lvl[1][1]});
        end
    end

    task automatic run(input int n);
        repeat (n) begin
            @(negedge CLK);
            npulse += int'(sw_on4);
        end
    endtask

    task automatic drive(input logic on, input logic off);
        sw_on_raw  = on;
        sw_off_raw = off;
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check_eq("reset_d4", obs[0], 4'b0000);
        check_eq("reset_d1", obs[1], 4'b0000);
        RST = 1'b1;
        chk_en = 1'b1;
        run(3);

        // clean press: pulse after edge 6 (D=4) and edge 3 (D=1)
        drive(1'b1, 1'b0);
        for (int e = 1; e <= 8; e++) begin
            @(negedge CLK);
            check_eq("press_d4", obs[0], {e == 6, 1'b0, e >= 6, 1'b0});
            check_eq("press_d1", obs[1], {e == 3, 1'b0, e >= 3, 1'b0});
        end
        run(12);
        drive(1'b0, 1'b0);
        run(10);

        // bounce 1,0,1,0,1 then hold
        npulse = 0;
        foreach (DC[k]) begin end
        for (int k = 0; k < 5; k++) begin
            drive(k % 2 == 0, 1'b0);
            run(1);
        end
        run(4);
        check_eq("bounce_nopulse", {2'b00, npulse[1:0]}, 4'b0000);
        run(10);
        check_eq("bounce_one", {2'b00, npulse[1:0]}, 4'b0001);
        drive(1'b0, 1'b0);
        run(10);

        // 3-cycle glitch on the off button
        drive(1'b0, 1'b1);
        run(3);
        drive(1'b0, 1'b0);
        for (int e = 1; e <= 8; e++) begin
            @(negedge CLK);
            check_eq("glitch_d4", {sw_off4, off_lvl4, 2'b00}, 4'b0000);
        end

        // simultaneous press
        drive(1'b1, 1'b1);
        for (int e = 1; e <= 8; e++) begin
            @(negedge CLK);
            check_eq("simul_d4", obs[0], {e == 6, e == 6, e >= 6, e >= 6});
        end
        drive(1'b0, 1'b0);
        run(10);

        // reset mid-count, button held through release
        drive(1'b1, 1'b0);
        repeat (4) @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        check_eq("async_rst_d4", obs[0], 4'b0000);
        check_eq("async_rst_d1", obs[1], 4'b0000);
        repeat (3) @(posedge CLK);
        #2 RST = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(posedge CLK);
            @(negedge CLK);
            check_eq("rst_requal_d4", obs[0], {e == 6, 1'b0, e >= 6, 1'b0});
            check_eq("rst_requal_d1", obs[1], {e == 3, 1'b0, e >= 3, 1'b0});
        end
        drive(1'b0, 1'b0);
        run(10);

        // repeat: press 10, release 10, press 10
        npulse = 0;
        drive(1'b1, 1'b0);
        run(10);
        drive(1'b0, 1'b0);
        for (int e = 1; e <= 10; e++) begin
            @(negedge CLK);
            npulse += int'(sw_on4);
            check_eq("release_lvl", {on_lvl4, 3'b000}, {e < 6, 3'b000});
        end
        drive(1'b1, 1'b0);
        run(10);
        drive(1'b0, 1'b0);
        run(10);
        check_eq("repeat_two", {2'b00, npulse[1:0]}, 4'b0010);

        // randomized segments: held levels, fast bouncing, occasional async reset
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 6)) begin
                    drive(1'($urandom), 1'($urandom));
                    run(1);
                end
            end else begin
                drive(1'($urandom), 1'($urandom));
                run($urandom_range(1, 10));
            end
            if ($urandom_range(0, 39) == 0) begin
                #1 RST = 1'b0;
                #1;
                check_eq("rand_rst", obs[0] | obs[1], 4'b0000);
                #1 RST = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
